scan_regbank_16: RTL and testbench
==================================

Name: scan_regbank_16

Overview:
- Sixteen-entry, WIDTH-bit register bank with one synchronous write port.
- Scan sequencer on top of the bank; drives the select of the downstream 16:1 word mux.
- Exposes all 16 stored words in parallel (mux data inputs 0..15) plus a 4-bit select that walks a programmed address range.
- Consumer reads the mux output under a valid/ready handshake; used for register dump, debug readout and display streaming.

Parameters:
- WIDTH, 32, bit width of each stored word and of wr_data.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset; sampled on rising edge of clock.
- wr_en  input  1  write strobe.
- wr_addr  input  4  write address 0..15.
- wr_data  input  WIDTH  write data.
- start  input  1  scan request; honoured only in IDLE.
- first_addr  input  4  first address of scan; captured on accepted start.
- last_addr  input  4  last address of scan; captured on accepted start.
- scan_ready  input  1  consumer accepts the current word.
- words_flat  output  16*WIDTH  word i on bits [i*WIDTH+WIDTH-1 : i*WIDTH]; feeds mux inputs in0..in15.
- scan_sel  output  4  select to the downstream mux.
- scan_valid  output  1  mux output at scan_sel is a valid scan beat.
- busy  output  1  high while in SCAN.
- done  output  1  one-cycle pulse when a scan completes.

Behaviour:
- Reset (reset==0 at a rising edge), regardless of state:
  - all 16 words = 0; state = IDLE.
  - scan_sel = 0, scan_valid = 0, busy = 0, done = 0.
  - captured last address = 0.
  - Reset mid-scan aborts the scan with no done pulse.
- Write path:
  - wr_en=1 at an edge: word[wr_addr] <= wr_data.
  - Address 0 is a normal writable entry (not hardwired zero).
  - Writes are legal in every state.
  - New value appears on words_flat the cycle after the edge.
- Scan sequencing:
  - Beat data is the downstream mux output, a combinational function of words_flat and scan_sel.
  - A write to the address currently presented changes the beat data from the next cycle.
  - The consumer samples on the handshake edge.
- FSM states: IDLE, SCAN, DONE.
- IDLE: scan_valid=0, busy=0, done=0.
  - start=1 at an edge: scan_sel <= first_addr, capture last_addr, go to SCAN.
  - scan_valid rises the cycle after start (1-cycle latency).
- SCAN: scan_valid=1, busy=1.
  - A beat transfers at an edge where scan_valid=1 and scan_ready=1.
  - Transfer with scan_sel == captured last: go to DONE; scan_sel holds.
  - Transfer otherwise: scan_sel <= scan_sel+1, modulo 16 (15 wraps to 0).
  - scan_ready=0: scan_sel and scan_valid hold; no beat lost or repeated.
  - start is ignored in SCAN.
- Range rules:
  - first==last: exactly one beat.
  - last<first: wrap-around scan, e.g. first=14, last=1 gives 14,15,0,1.
  - first=0, last=15: full 16-beat scan.
  - Beats per scan = ((last-first) mod 16) + 1.
- DONE: done=1 and scan_valid=0 for exactly one cycle, then IDLE.
  - start in DONE is ignored; earliest re-start is the first IDLE cycle.
- Simultaneous events:
  - wr_en plus a handshake in the same cycle: both take effect.
  - start plus wr_en in IDLE: both take effect; the first beat shows the written value if addresses coincide.
- Outputs are registered, except that scan_valid/busy/done may be decoded directly from state registers.

Test Plan:
- Reset clears: write 0xDEADBEEF to addr 5, pulse reset low for 1 cycle -> words_flat all 0, scan_sel=0, scan_valid=0, busy=0.
- Full scan, ready tied high:
  - Stimulus: write word i = 0x100+i; start with first=0, last=15.
  - Response: scan_valid high for 16 consecutive cycles; scan_sel 0..15; beat data 0x100..0x10F.
  - Then done=1 for 1 cycle and busy falls.
- Wrap and single beat:
  - first=14, last=1 -> sel sequence 14,15,0,1, then done.
  - first=first=7, last=7 -> one beat, sel=7, then done.
- Backpressure:
  - Stimulus: first=2, last=4; scan_ready toggled 1,0,0,1,1.
  - Response: sel 2 transfers, holds at 3 for two cycles, then 3 and 4 transfer; exactly 3 beats, no duplicates.
- Write during scan:
  - Stimulus: scan stalled at sel=3 with ready=0; write addr 3 = 0xCAFE0003.
  - Response: next cycle's beat data = 0xCAFE0003; on ready=1 that value transfers.
- Abort and ignored start:
  - start during SCAN -> no effect on scan_sel.
  - reset low mid-scan at sel=9 -> IDLE next cycle, no done pulse, words cleared.
  - A subsequent start works normally.

Source files
------------

// File: rtl/scan_regbank_16.sv
// Sixteen-entry register bank with a scan sequencer that walks a programmed
// address range and drives the select of a downstream 16:1 word mux.
module scan_regbank_16 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [3:0]            wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  start,
  input  logic [3:0]            first_addr,
  input  logic [3:0]            last_addr,
  input  logic                  scan_ready,
  output logic [16*WIDTH-1:0]   words_flat,
  output logic [3:0]            scan_sel,
  output logic                  scan_valid,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] words [16];
  logic [3:0]       last_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 16; i++) begin
        words[i] <= '0;
      end
    end else if (wr_en) begin
      words[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    words_flat = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      words_flat[i*WIDTH +: WIDTH] = words[i];
    end
  end

  // scan_sel wraps naturally through its 4-bit width, giving modulo-16 ranges.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      scan_sel <= '0;
      last_q   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            scan_sel <= first_addr;
            last_q   <= last_addr;
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (scan_ready) begin
            if (scan_sel == last_q) begin
              state <= DONE;
            end else begin
              scan_sel <= scan_sel + 4'd1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign scan_valid = (state == SCAN);
  assign busy       = (state == SCAN);
  assign done       = (state == DONE);

endmodule

// File: tb/tb_scan_regbank_16.sv
// Directed bench for scan_regbank_16: reset, full/wrap/single scans,
// backpressure, write-during-scan, ignored start and mid-scan reset.
module tb_scan_regbank_16;

  localparam int unsigned W = 32;

  logic             clock = 1'b0;
  logic             reset;
  logic             wr_en;
  logic [3:0]       wr_addr;
  logic [W-1:0]     wr_data;
  logic             start;
  logic [3:0]       first_addr;
  logic [3:0]       last_addr;
  logic             scan_ready;
  logic [16*W-1:0]  words_flat;
  logic [3:0]       scan_sel;
  logic             scan_valid;
  logic             busy;
  logic             done;

  int checks   = 0;
  int failures = 0;
  int beats    = 0;

  scan_regbank_16 #(.WIDTH(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .start      (start),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .scan_ready (scan_ready),
    .words_flat (words_flat),
    .scan_sel   (scan_sel),
    .scan_valid (scan_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_words(input string tag, input logic [16*W-1:0] exp);
    checks++;
    assert (words_flat === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, words_flat, exp);
    end
  endtask

  function automatic logic [W-1:0] beat();
    return words_flat[scan_sel*W +: W];
  endfunction

  task automatic state_chk(input string tag, input logic v, input logic b, input logic d);
    chk({tag, "_valid"}, 64'(scan_valid), 64'(v));
    chk({tag, "_busy"},  64'(busy),       64'(b));
    chk({tag, "_done"},  64'(done),       64'(d));
  endtask

  logic [16*W-1:0] model;
  logic [3:0]      wrap_seq [4];

  initial begin
    reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; first_addr = '0; last_addr = '0; scan_ready = 1'b0;
    model = '0;
    tick(); tick();
    reset = 1'b1;
    tick();
    chk_words("por_words", model);
    chk("por_sel", 64'(scan_sel), 64'd0);
    state_chk("por", 1'b0, 1'b0, 1'b0);

    // Reset clears a written word
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'hDEADBEEF;
    tick();
    wr_en = 1'b0;
    chk("w5", 64'(words_flat[5*W +: W]), 64'hDEADBEEF);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk_words("rst_words", '0);
    chk("rst_sel", 64'(scan_sel), 64'd0);
    state_chk("rst", 1'b0, 1'b0, 1'b0);

    // Full scan with ready high
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = 32'h100 + 32'(i);
      model[i*W +: W] = 32'h100 + 32'(i);
      tick();
    end
    wr_en = 1'b0;
    chk_words("fill_words", model);
    scan_ready = 1'b1; start = 1'b1; first_addr = 4'd0; last_addr = 4'd15;
    chk("idle_valid", 64'(scan_valid), 64'd0);
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("full_valid", 64'(scan_valid), 64'd1);
      chk("full_sel", 64'(scan_sel), 64'(i));
      chk("full_beat", 64'(beat()), 64'h100 + 64'(i));
      tick();
    end
    state_chk("full_end", 1'b0, 1'b0, 1'b1);
    tick();
    state_chk("full_idle", 1'b0, 1'b0, 1'b0);

    // Wrap-around 14..1
    wrap_seq[0] = 4'd14; wrap_seq[1] = 4'd15; wrap_seq[2] = 4'd0; wrap_seq[3] = 4'd1;
    start = 1'b1; first_addr = 4'd14; last_addr = 4'd1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("wrap_sel", 64'(scan_sel), 64'(wrap_seq[i]));
      chk("wrap_valid", 64'(scan_valid), 64'd1);
      tick();
    end
    state_chk("wrap_end", 1'b0, 1'b0, 1'b1);
    tick();

    // Single beat; start in DONE ignored, accepted in following IDLE
    start = 1'b1; first_addr = 4'd7; last_addr = 4'd7;
    tick();
    start = 1'b0;
    chk("one_sel", 64'(scan_sel), 64'd7);
    chk("one_beat", 64'(beat()), 64'h107);
    tick();
    state_chk("one_end", 1'b0, 1'b0, 1'b1);
    start = 1'b1; first_addr = 4'd3; last_addr = 4'd3;
    tick();
    state_chk("done_start_ign", 1'b0, 1'b0, 1'b0);
    chk("done_start_sel", 64'(scan_sel), 64'd7);
    tick();
    start = 1'b0;
    chk("restart_sel", 64'(scan_sel), 64'd3);
    chk("restart_busy", 64'(busy), 64'd1);
    tick();
    chk("restart_done", 64'(done), 64'd1);
    tick();

    // Backpressure 2..4 with ready 1,0,0,1,1
    start = 1'b1; first_addr = 4'd2; last_addr = 4'd4;
    tick();
    start = 1'b0;
    beats = 0;
    scan_ready = 1'b1; chk("bp_sel0", 64'(scan_sel), 64'd2);
    if (scan_valid && scan_ready) beats++;
    tick();
    scan_ready = 1'b0; chk("bp_sel1", 64'(scan_sel), 64'd3);
    if (scan_valid && scan_ready) beats++;
    tick();
    scan_ready = 1'b0; chk("bp_sel2", 64'(scan_sel), 64'd3);
    chk("bp_hold_valid", 64'(scan_valid), 64'd1);
    if (scan_valid && scan_ready) beats++;
    tick();
    scan_ready = 1'b1; chk("bp_sel3", 64'(scan_sel), 64'd3);
    if (scan_valid && scan_ready) beats++;
    tick();
    scan_ready = 1'b1; chk("bp_sel4", 64'(scan_sel), 64'd4);
    chk("bp_beat4", 64'(beat()), 64'h104);
    if (scan_valid && scan_ready) beats++;
    tick();
    chk("bp_beats", 64'(beats), 64'd3);
    state_chk("bp_end", 1'b0, 1'b0, 1'b1);
    tick();

    // Write to the presented address while stalled
    scan_ready = 1'b0; start = 1'b1; first_addr = 4'd3; last_addr = 4'd5;
    tick();
    start = 1'b0;
    chk("ws_beat_old", 64'(beat()), 64'h103);
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'hCAFE0003;
    tick();
    wr_en = 1'b0;
    chk("ws_sel", 64'(scan_sel), 64'd3);
    chk("ws_beat_new", 64'(beat()), 64'hCAFE0003);
    scan_ready = 1'b1;
    tick();
    // simultaneous write and handshake
    chk("ws_sel4", 64'(scan_sel), 64'd4);
    wr_en = 1'b1; wr_addr = 4'd9; wr_data = 32'h0000_0999;
    tick();
    wr_en = 1'b0;
    chk("ws_sel5", 64'(scan_sel), 64'd5);
    chk("ws_w9", 64'(words_flat[9*W +: W]), 64'h999);
    tick();
    chk("ws_done", 64'(done), 64'd1);
    tick();

    // Ignored start in SCAN, then reset at sel=9
    start = 1'b1; first_addr = 4'd8; last_addr = 4'd12;
    tick();
    first_addr = 4'd0; last_addr = 4'd0;
    chk("ab_sel8", 64'(scan_sel), 64'd8);
    tick();
    start = 1'b0;
    chk("ab_sel9", 64'(scan_sel), 64'd9);
    chk("ab_beat9", 64'(beat()), 64'h999);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    state_chk("ab_rst", 1'b0, 1'b0, 1'b0);
    chk("ab_rst_sel", 64'(scan_sel), 64'd0);
    chk_words("ab_rst_words", '0);
    tick();
    chk("ab_no_done", 64'(done), 64'd0);

    // Restart after abort, with a simultaneous write to the first address
    start = 1'b1; first_addr = 4'd1; last_addr = 4'd1;
    wr_en = 1'b1; wr_addr = 4'd1; wr_data = 32'h55;
    tick();
    start = 1'b0; wr_en = 1'b0;
    chk("rs_sel", 64'(scan_sel), 64'd1);
    chk("rs_beat", 64'(beat()), 64'h55);
    chk("rs_valid", 64'(scan_valid), 64'd1);
    tick();
    state_chk("rs_end", 1'b0, 1'b0, 1'b1);
    tick();
    state_chk("rs_idle", 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
